// File: rtl/esm_pkg.sv
// Shared definitions for the ESM dependency scoreboard: instruction field
// offsets, the per-entry state encoding and a one-hot helper.
package esm_pkg;

  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int RD_LSB      = 7;
  localparam int REG_FIELD_W = 5;
  localparam int MAX_BS      = 64;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    ISSUED = 2'd2
  } entry_state_e;

  // One-hot of a slot index, or all zeros when the source has no live producer.
  function automatic logic [MAX_BS-1:0] onehot_f(input int unsigned idx, input logic valid);
    onehot_f = '0;
    if (valid) onehot_f[idx[5:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-index priority encoder; idx_o is 0 when nothing is requested.
module esm_prio_enc #(
  parameter  int W  = 16,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/esm_dep_scoreboard.sv
// BS-entry instruction window with RAW dependency masks and lowest-index issue pick.
// Define ESM_WAW_TRACK_EN to also order writes to the same destination register.
module esm_dep_scoreboard
  import esm_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int REGNUM = 32,
  parameter  int BS     = 16,
  parameter  int NCMP   = 2,
  localparam int IW     = $clog2(BS),
  localparam int OW     = $clog2(BS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  logic [XLEN-1:0]  alloc_instr_i,
  input  logic             alloc_rs2_en_i,
  input  logic             alloc_rd_en_i,
  output logic [IW-1:0]    alloc_idx_o,
  output logic [BS-1:0]    ready_index_o,
  output logic             issue_sel_valid_o,
  output logic [IW-1:0]    issue_sel_idx_o,
  input  logic             issue_en_i,
  input  logic [IW-1:0]    issue_idx_i,
  input  logic [NCMP-1:0]  cmpl_valid_i,
  input  logic [NCMP*IW-1:0] cmpl_idx_i,
  output logic [OW-1:0]    occupancy_o
);

  entry_state_e      state_q [BS];
  entry_state_e      state_d [BS];
  logic [BS-1:0]     dep_q [BS];
  logic [BS-1:0]     dep_d [BS];
  logic [IW-1:0]     wr_idx_q [REGNUM];
  logic [IW-1:0]     wr_idx_d [REGNUM];
  logic [REGNUM-1:0] wr_vld_q, wr_vld_d;

  logic [BS-1:0] free_vec, ready_vec, cmpl_vec, cmpl_eff, new_dep;
  logic [MAX_BS-1:0] oh_all;
  logic [OW-1:0] occ;
  logic          alloc_fire;
  logic [REG_FIELD_W-1:0] rs1, rs2, rd;

  assign rs1 = alloc_instr_i[RS1_LSB +: REG_FIELD_W];
  assign rs2 = alloc_rs2_en_i ? alloc_instr_i[RS2_LSB +: REG_FIELD_W] : '0;
  assign rd  = alloc_rd_en_i  ? alloc_instr_i[RD_LSB  +: REG_FIELD_W] : '0;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    occ       = '0;
    for (int i = 0; i < BS; i++) begin
      free_vec[i]  = (state_q[i] == FREE);
      ready_vec[i] = (state_q[i] == WAIT) && (dep_q[i] == '0);
      if (state_q[i] != FREE) occ = occ + OW'(1);
    end
  end

  esm_prio_enc #(.W(BS)) u_free_pick (
    .req_i(free_vec), .idx_o(alloc_idx_o), .valid_o(alloc_ready_o)
  );

  esm_prio_enc #(.W(BS)) u_issue_pick (
    .req_i(ready_vec), .idx_o(issue_sel_idx_o), .valid_o(issue_sel_valid_o)
  );

  assign ready_index_o = ready_vec;
  assign occupancy_o   = occ;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  // Only completions of issued slots take effect; duplicates collapse in the OR.
  always_comb begin
    cmpl_vec = '0;
    for (int p = 0; p < NCMP; p++) begin
      if (cmpl_valid_i[p]) cmpl_vec[cmpl_idx_i[p*IW +: IW]] = 1'b1;
    end
    cmpl_eff = '0;
    for (int i = 0; i < BS; i++) cmpl_eff[i] = cmpl_vec[i] && (state_q[i] == ISSUED);
  end

  always_comb begin
    oh_all = onehot_f(int'(wr_idx_q[rs1]), (rs1 != '0) && wr_vld_q[rs1])
           | onehot_f(int'(wr_idx_q[rs2]), (rs2 != '0) && wr_vld_q[rs2]);
`ifdef ESM_WAW_TRACK_EN
    oh_all = oh_all | onehot_f(int'(wr_idx_q[rd]), (rd != '0) && wr_vld_q[rd]);
`endif
    new_dep = oh_all[BS-1:0] & ~cmpl_eff;
  end

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      state_d[i] = cmpl_eff[i] ? FREE : state_q[i];
      dep_d[i]   = dep_q[i] & ~cmpl_eff;
    end
    if (issue_en_i && ready_vec[issue_idx_i]) state_d[issue_idx_i] = ISSUED;
    if (alloc_fire) begin
      state_d[alloc_idx_o] = WAIT;
      dep_d[alloc_idx_o]   = new_dep;
    end
    for (int r = 0; r < REGNUM; r++) begin
      wr_idx_d[r] = wr_idx_q[r];
      wr_vld_d[r] = wr_vld_q[r] && !cmpl_eff[wr_idx_q[r]];
    end
    // A same-edge allocation rewriting the register wins over invalidation.
    if (alloc_fire && (rd != '0)) begin
      wr_idx_d[rd] = alloc_idx_o;
      wr_vld_d[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= FREE;
        dep_q[i]   <= '0;
      end
      for (int r = 0; r < REGNUM; r++) wr_idx_q[r] <= '0;
      wr_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      dep_q    <= dep_d;
      wr_idx_q <= wr_idx_d;
      wr_vld_q <= wr_vld_d;
    end
  end

  logic unused_instr;
  assign unused_instr = ^{alloc_instr_i[XLEN-1:RS2_LSB+REG_FIELD_W],
                          alloc_instr_i[RS1_LSB-1:RD_LSB+REG_FIELD_W],
                          alloc_instr_i[RD_LSB-1:0]};

  if (BS < MAX_BS) begin : g_oh_sink
    logic unused_oh;
    assign unused_oh = ^oh_all[MAX_BS-1:BS];
  end

endmodule

// File: doc/esm_dep_scoreboard.md
Name: esm_dep_scoreboard

Overview:
- Parametrised successor to the single-instruction IRT/IDT dependency pair in the ESM core.
- Owns a BS-entry instruction window: allocates slots, builds each new entry's RAW dependency mask from a per-register last-writer table, and exposes a ready vector plus a lowest-index issue pick.
- Clears dependency columns on up to NCMP completions per cycle.
- Sits between decode and the issue/execute stage.

Parameters:
- XLEN, 32, instruction word width (fields taken from RISC-V positions rs1[19:15], rs2[24:20], rd[11:7]).
- REGNUM, 32, architectural registers; register 0 is never tracked.
- BS, 16, window depth in entries; power of two, 4..64.
- NCMP, 2, completion ports per cycle, 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  decode presents an instruction.
- alloc_ready  out  1  at least one free slot.
- alloc_instr  in  XLEN  instruction word.
- alloc_rs2_en  in  1  rs2 is a real source (0: treat as x0).
- alloc_rd_en  in  1  instruction writes rd (0: treat as x0).
- alloc_idx  out  $clog2(BS)  slot to be used by the current allocation; valid when alloc_ready.
- ready_index  out  BS  entries that are valid, not issued, and have an all-zero dependency mask.
- issue_sel_valid  out  1  |ready_index.
- issue_sel_idx  out  $clog2(BS)  lowest set bit of ready_index.
- issue_en  in  1  mark issue_idx as issued.
- issue_idx  in  $clog2(BS)  slot being issued.
- cmpl_valid  in  NCMP  per-port completion strobe.
- cmpl_idx  in  NCMP*$clog2(BS)  per-port completing slot, packed with port 0 in the LSBs.
- occupancy  out  $clog2(BS+1)  number of non-free slots.

Behaviour:
- Reset (rst low, asynchronous):
  - All entries FREE; dep masks 0; writer table invalid.
  - Outputs: occupancy=0, ready_index=0, issue_sel_valid=0, alloc_ready=1, alloc_idx=0, issue_sel_idx=0.
  - Applies immediately even mid-operation; in-flight state is discarded.
- Entry states:
  - FREE -> WAIT on allocation handshake (alloc_valid & alloc_ready at a clk edge).
  - WAIT -> ISSUED on issue_en with issue_idx equal to the slot, only if ready_index[slot] is set. Otherwise the issue is ignored.
  - ISSUED -> FREE on any cmpl_valid[p] naming the slot. Completion of a FREE or WAIT slot is ignored.
- Allocation:
  - alloc_idx = lowest FREE slot, from registered state.
  - A slot freed in cycle N is allocatable from cycle N+1.
- Dependency mask of the new entry:
  - OR of onehot(writer[rs1]) and onehot(writer[rs2]) for each source whose register is non-zero and whose writer entry is valid.
  - Bits for slots completing in the same cycle are masked off (same-cycle bypass).
- Writer table:
  - If alloc_rd_en and rd!=0, writer[rd] <= alloc slot and valid <= 1.
  - On completion of slot s, every writer entry equal to s is invalidated, unless the same edge's allocation rewrites that register (allocation wins).
- Completion:
  - Clears column s in every entry's mask on the same edge.
  - Duplicate idx on two ports is equivalent to one completion.
- Timing:
  - ready_index is combinational from registered state only, so there is no input-to-output path.
  - A newly allocated entry with no dependencies appears in ready_index one cycle after the handshake.
  - An entry whose last producer completes at edge N is ready after edge N.
- occupancy updates each edge: +1 on allocation, −(number of distinct valid completions).
- Full window: alloc_ready=0; alloc_valid is held by the producer.
- Empty window: ready_index=0, issue_sel_valid=0.
- Self-dependence (rs1==rd) uses the prior writer, never the allocating slot.

Optional Feature:
- ESM_WAW_TRACK_EN
  - Defined: the new entry's mask additionally includes onehot(writer[rd]) when rd!=0 and writer valid, giving in-order writes per register.
  - Undefined: RAW only; no WAW logic is generated.

Decomposition:
- Shared package esm_pkg holds:
  - localparams for field offsets (RS1_LSB=15, RS2_LSB=20, RD_LSB=7, REG_FIELD_W=5);
  - the entry-state typedef (FREE/WAIT/ISSUED);
  - a function onehot_f(idx, valid).
- One sub-module: esm_prio_enc, a parametrised lowest-index priority encoder.
  - Used twice: once for the free-slot pick and once for issue_sel_idx.

Test Plan:
1. Reset, then 16 allocations of independent instructions with no issues -> alloc_ready=0 after the 16th, occupancy=16, ready_index=16'hFFFF.
2. Alloc slot0 "add x5,x1,x2" then slot1 "add x6,x5,x3" -> ready_index=16'h0001. Issue 0, complete 0 -> next cycle ready_index=16'h0002.
3. Same cycle: complete slot3 (writer of x7) and allocate a reader of x7 -> new entry ready next cycle; slot3 is not reused that cycle (alloc_idx≠3).
4. cmpl_valid=2'b11 with both ports on slot2 -> occupancy drops by 1; slot2 is FREE.
5. Allocation with rd=x0 and rd_en=1 -> writer table unchanged; a later reader of x0 has dep mask 0.
6. With ESM_WAW_TRACK_EN: two writers of x9 -> second entry is not ready until the first completes. Without the macro: both ready immediately.
